// File: rtl/fetch_unit_if.sv
// fetch_unit_if: signal bundle between the fetch unit, instruction memory,
// the branch resolver and decode.
//   imem_addr/imem_inst       : memory address out, read data in (1-cycle latency)
//   branch_taken/branch_target: redirect request and target word address
//   fd_valid/fd_ready         : fetch->decode handshake
//   fd_inst/fd_pc             : instruction and its word address
//   fetch_fault               : sticky out-of-range fetch flag
// master = fetch unit side, slave = environment side.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        fd_valid;
    logic        fd_ready;
    logic [31:0] fd_inst;
    logic [31:0] fd_pc;
    logic        fetch_fault;

    modport master (
        output imem_addr, fd_valid, fd_inst, fd_pc, fetch_fault,
        input  imem_inst, branch_taken, branch_target, fd_ready
    );

    modport slave (
        input  imem_addr, fd_valid, fd_inst, fd_pc, fetch_fault,
        output imem_inst, branch_taken, branch_target, fd_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Drives the PC to a synchronous instruction memory, tracks one read in
// flight and buffers returned words in a 2-entry {inst, pc} FIFO whose head
// is presented to decode.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   fu      : fetch_unit_if.master (memory, branch redirect, decode handshake)
// Parameters:
//   RESET_PC  : first word address fetched after reset
//   MEM_DEPTH : memory depth in words, used by the optional range check
// Optional feature: define FETCH_BOUNDS_CHECK_EN to stop fetching at
// PC >= MEM_DEPTH and raise a sticky fetch_fault (cleared by redirect/reset).
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          MEM_DEPTH = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    fetch_unit_if.master fu
);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fd_ent_t;

    logic [31:0] pc_q;
    logic        infl_q;
    logic [31:0] infl_pc_q;
    logic [1:0]  count_q;
    fd_ent_t     head_q, tail_q;
    logic        fault_q;

    logic        pop, space, in_range, issue, fault_set;
    logic [2:0]  occ;
    logic [1:0]  cnt_after_pop;
    fd_ent_t     wr_ent;

    always_comb begin
        pop           = (count_q != 2'd0) && fu.fd_ready;
        // Slots that will be occupied once the current in-flight read lands;
        // issuing only when at most one is taken guarantees no overflow.
        occ           = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop};
        space         = (occ <= 3'd1);
        in_range      = (pc_q < 32'(MEM_DEPTH));
        issue         = space && (!BOUNDS_EN || (!fault_q && in_range));
        fault_set     = BOUNDS_EN && space && !fault_q && !in_range;
        cnt_after_pop = count_q - {1'b0, pop};
        wr_ent        = '{inst: fu.imem_inst, pc: infl_pc_q};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q      <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
            count_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            fault_q   <= 1'b0;
        end else if (fu.branch_taken) begin
            // Redirect: drop buffered and in-flight work; head keeps its last
            // value so the outputs stay stable while empty.
            pc_q    <= fu.branch_target;
            infl_q  <= 1'b0;
            count_q <= '0;
            fault_q <= 1'b0;
        end else begin
            if (pop && count_q == 2'd2)
                head_q <= tail_q;
            if (infl_q) begin
                if (cnt_after_pop == 2'd0)
                    head_q <= wr_ent;
                else
                    tail_q <= wr_ent;
            end
            count_q   <= cnt_after_pop + {1'b0, infl_q};
            infl_q    <= issue;
            infl_pc_q <= pc_q;
            if (issue)
                pc_q <= pc_q + 32'd1;
            if (fault_set)
                fault_q <= 1'b1;
        end
    end

    assign fu.imem_addr = pc_q;
    assign fu.fd_valid  = (count_q != 2'd0);
    assign fu.fd_inst   = head_q.inst;
    assign fu.fd_pc     = head_q.pc;
`ifdef FETCH_BOUNDS_CHECK_EN
    assign fu.fetch_fault = fault_q;
`else
    assign fu.fetch_fault = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 0: word address fetched first after reset.
REQ-002 SHALL have parameter MEM_DEPTH, default 32: instruction memory depth in words, used only by the bounds check.
REQ-003 SHALL have port clock, input, 1 bit: single clock, all state updated on rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port imem_addr, output, 32 bits: word address to instruction memory; memory returns the word on the next rising edge.
REQ-006 SHALL have port imem_inst, input, 32 bits: memory read data, valid one cycle after the address it answers.
REQ-007 SHALL have port branch_taken, input, 1 bit: redirect request, sampled each rising edge.
REQ-008 SHALL have port branch_target, input, 32 bits: word address to redirect to.
REQ-009 SHALL have port fd_valid, output, 1 bit: fd_inst/fd_pc hold a valid instruction.
REQ-010 SHALL have port fd_ready, input, 1 bit: decode accepts; transfer occurs when fd_valid && fd_ready at a rising edge.
REQ-011 SHALL have port fd_inst, output, 32 bits: fetched instruction.
REQ-012 SHALL have port fd_pc, output, 32 bits: word address of fd_inst.
REQ-013 SHALL have port fetch_fault, output, 1 bit: sticky out-of-range fetch flag.

Function
REQ-014 SHALL hold a PC register; imem_addr SHALL equal PC combinationally.
REQ-015 SHALL contain a 2-entry output FIFO of {inst, pc}; fd_* SHALL present its head; fd_valid = FIFO non-empty.
REQ-016 SHALL track one in-flight flag plus its PC; an issue in cycle t SHALL write imem_inst with that PC into the FIFO at the end of cycle t+1.
REQ-017 SHALL issue in a cycle iff (fifo_count + inflight − pop) <= 1 and no fault holds, where pop = fd_valid && fd_ready; on issue PC <= PC+1 (mod 2^32).
REQ-018 SHALL sustain one instruction per cycle while fd_ready stays high; first fd_valid SHALL rise 2 cycles after the address is first driven.
REQ-019 SHALL never drop or duplicate an instruction when fd_ready deasserts; the FIFO SHALL never overflow.
REQ-020 While fd_valid && !fd_ready, fd_inst and fd_pc SHALL stay stable.
REQ-021 On branch_taken at an edge: FIFO cleared, in-flight squashed, PC <= branch_target, fetch_fault cleared; a same-edge pop SHALL count as completed.
REQ-022 After redirect at edge e, imem_addr = branch_target in the following cycle and fd_valid SHALL rise 2 edges after e with fd_pc = branch_target.
REQ-023 A FIFO write and pop at the same edge SHALL both take effect; count unchanged.
REQ-024 When the FIFO is empty, fd_inst and fd_pc SHALL hold their last values.

Reset
REQ-025 reset_n low SHALL immediately set PC = RESET_PC, empty the FIFO, and clear the in-flight flag.
REQ-026 During reset, fd_valid = 0, fd_inst = 0, fd_pc = 0, fetch_fault = 0.
REQ-027 Reset asserted mid-stream SHALL discard all pending instructions; after release fetch restarts from RESET_PC.
REQ-028 The first issue SHALL occur in the first cycle after reset_n deasserts.

Configuration
REQ-029 Macro FETCH_BOUNDS_CHECK_EN defined: issuing with PC >= MEM_DEPTH SHALL NOT occur; instead fetch_fault SHALL set and stay set, and issue SHALL stop until branch_taken or reset.
REQ-030 Already-issued and buffered instructions SHALL still drain normally under a fault.
REQ-031 Macro FETCH_BOUNDS_CHECK_EN undefined: no range check, PC wraps modulo 2^32, fetch_fault SHALL be tied 0.

Verification
REQ-032 Reset release, fd_ready=1, memory word k = k+0x100 -> fd_valid rises at edge 2; fd_pc 0,1,2,... with fd_inst 0x100,0x101,... on consecutive cycles.
REQ-033 fd_ready low for 5 cycles mid-stream -> fd_pc/fd_inst frozen, no gaps or duplicates after fd_ready returns.
REQ-034 branch_taken with branch_target=0x10 while the FIFO holds 2 entries -> no further stale output; the next fd_pc is 0x10, 2 edges later.
REQ-035 reset_n pulsed low mid-stream -> fd_valid drops immediately; the sequence restarts at fd_pc=RESET_PC.
REQ-036 With FETCH_BOUNDS_CHECK_EN, MEM_DEPTH=32 -> fd_pc reaches 31, then fetch_fault=1 and fd_valid stays 0; branch_taken to 0 clears the fault and resumes fetch.
REQ-037 branch_taken and pop at the same edge -> popped instruction counted once; next fd_pc equals branch_target.
